// File: rtl/atualiza_posicao_pkg.sv
// Shared constants for the object position-update stage: screen geometry,
// coordinate width and FSM state encoding.
package atualiza_posicao_pkg;

  localparam int unsigned W_COORD      = 8;
  localparam int unsigned LARGURA_TELA = 160;
  localparam int unsigned ALTURA_TELA  = 120;

  localparam logic [2:0] OCIOSO  = 3'd0;
  localparam logic [2:0] LE      = 3'd1;
  localparam logic [2:0] CALCULA = 3'd2;
  localparam logic [2:0] ESCREVE = 3'd3;
  localparam logic [2:0] FIM     = 3'd4;

endpackage

// File: rtl/ajuste_borda.sv
// One-axis coordinate update: add or subtract the speed, then wrap into 0..L-1.
module ajuste_borda #(
  parameter int unsigned W = 8,
  parameter int unsigned L = 160
) (
  input  logic [W-1:0] pos,
  input  logic [W-1:0] vel,
  input  logic         sub,
  output logic [W-1:0] novo
);

  localparam logic [W:0]   LIM   = L[W:0];
  localparam logic [W-1:0] LIM_W = L[W-1:0];

  logic [W:0] w_soma;
  logic [W:0] w_dif;

  always_comb begin
    w_soma = {1'b0, pos} + {1'b0, vel};
    w_dif  = {1'b0, pos} - {1'b0, vel};
    if (sub) begin
      // Borrow out of bit W means the result went negative: wrap by adding L.
      novo = w_dif[W] ? (w_dif[W-1:0] + LIM_W) : w_dif[W-1:0];
    end else begin
      novo = (w_soma >= LIM) ? (w_soma[W-1:0] - LIM_W) : w_soma[W-1:0];
    end
  end

endmodule

// File: rtl/atualiza_posicao.sv
// Per-frame sweep over the object bank: read, update with wrap-around, write back.
module atualiza_posicao
  import atualiza_posicao_pkg::*;
#(
  parameter int unsigned W       = W_COORD,
  parameter int unsigned LARGURA = LARGURA_TELA,
  parameter int unsigned ALTURA  = ALTURA_TELA,
  parameter int unsigned NUM_OBJ = 4,
  parameter int unsigned IW      = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          iniciar,
  output logic [IW-1:0] endereco,
  input  logic [W-1:0]  pos_x,
  input  logic [W-1:0]  pos_y,
  input  logic [W-1:0]  vel_x,
  input  logic [W-1:0]  vel_y,
  input  logic          sub_x,
  input  logic          sub_y,
  input  logic          ativo,
  output logic [W-1:0]  novo_x,
  output logic [W-1:0]  novo_y,
  output logic          escreve,
  output logic          ocupado,
  output logic          pronto
);

  localparam logic [IW-1:0] ULTIMO = IW'(NUM_OBJ - 1);

  logic [2:0]    r_estado;
  logic [2:0]    w_prox;
  logic [IW-1:0] r_indice;
  logic [W-1:0]  r_novo_x;
  logic [W-1:0]  r_novo_y;
  logic          r_ativo;
  logic [W-1:0]  w_calc_x;
  logic [W-1:0]  w_calc_y;
  logic          w_ultimo;

  ajuste_borda #(
    .W (W),
    .L (LARGURA)
  ) u_borda_x (
    .pos  (pos_x),
    .vel  (vel_x),
    .sub  (sub_x),
    .novo (w_calc_x)
  );

  ajuste_borda #(
    .W (W),
    .L (ALTURA)
  ) u_borda_y (
    .pos  (pos_y),
    .vel  (vel_y),
    .sub  (sub_y),
    .novo (w_calc_y)
  );

  assign w_ultimo = (r_indice == ULTIMO);

  always_comb begin
    w_prox = r_estado;
    case (r_estado)
      OCIOSO:  if (iniciar) w_prox = LE;
      LE:      w_prox = CALCULA;
      CALCULA: w_prox = ESCREVE;
      ESCREVE: w_prox = w_ultimo ? FIM : LE;
      FIM:     w_prox = OCIOSO;
      default: w_prox = OCIOSO;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_estado <= OCIOSO;
      r_indice <= '0;
      r_novo_x <= '0;
      r_novo_y <= '0;
      r_ativo  <= 1'b0;
    end else begin
      r_estado <= w_prox;
      if (r_estado == OCIOSO && iniciar) begin
        r_indice <= '0;
      end else if (r_estado == ESCREVE && !w_ultimo) begin
        r_indice <= r_indice + IW'(1);
      end
      // Bank read data is valid during CALCULA (one cycle after LE set the address).
      if (r_estado == CALCULA) begin
        r_ativo  <= ativo;
        r_novo_x <= w_calc_x;
        r_novo_y <= w_calc_y;
      end
    end
  end

  assign endereco = r_indice;
  assign novo_x   = r_novo_x;
  assign novo_y   = r_novo_y;
  assign escreve  = (r_estado == ESCREVE) && r_ativo;
  assign ocupado  = (r_estado != OCIOSO);
  assign pronto   = (r_estado == FIM);

endmodule
